fetch_sequencer: RTL and testbench
==================================

# fetch_sequencer

Instruction-fetch controller that owns the program counter. It issues word fetches to instruction memory over a valid/ready request channel and accepts responses over a valid/ready response channel. Each returned instruction is buffered in a one-entry output slot, together with its PC, for the decode stage. It handles stalls from decode and branch/jump redirects from execute, and discards stale responses after a redirect.

## Interface

Parameters:
- RESET_VECTOR, 32'h0000_0000, first fetch address after reset; bits [1:0] must be 0.

Ports:
- clk  input  1  clock; all state updates on posedge.
- reset_n  input  1  asynchronous, active-low reset.
- imem_req_valid  output  1  fetch request valid.
- imem_req_ready  input  1  memory accepts request this cycle.
- imem_req_addr  output  32  fetch address; always word-aligned.
- imem_resp_valid  input  1  response data valid.
- imem_resp_ready  output  1  sequencer accepts response this cycle.
- imem_resp_data  input  32  fetched instruction word.
- redirect_valid  input  1  one-cycle redirect pulse from execute.
- redirect_pc  input  32  redirect target; bits [1:0] ignored (forced 0).
- stall  input  1  decode cannot consume the slot this cycle.
- inst_valid  output  1  output slot holds an instruction.
- inst_data  output  32  instruction word.
- inst_pc  output  32  address the instruction was fetched from.

## Operation

- Reset values: state BOOT, pc = RESET_VECTOR, imem_req_valid=0, imem_resp_ready=0, inst_valid=0, inst_data=0, inst_pc=0.
- States: BOOT, REQ, WAIT, DRAIN. Exactly one request is outstanding at most.
- BOOT: imem_req_valid=0 -> REQ unconditionally on the next edge.
- REQ: imem_req_valid=1, imem_req_addr=pc. Valid and address are held until handshake (valid && ready). On handshake: fetch_pc <= pc, pc <= pc+4, -> WAIT.
- WAIT: imem_resp_ready=1 iff slot empty or slot consumed this cycle (inst_valid && !stall). On response handshake: slot <= {1, resp_data, fetch_pc}, -> REQ.
- Slot consumption: inst_valid && !stall on a cycle clears inst_valid unless it is reloaded in the same cycle.
- Redirect (has priority over everything, including stall):
  - slot flushed (inst_valid=0 next cycle); pc <= {redirect_pc[31:2],2'b00}.
  - In REQ without handshake: stay REQ. The address changes to the target next cycle; this is the only permitted withdrawal/change of a pending request.
  - In REQ with handshake the same cycle: -> DRAIN.
  - In WAIT without response: -> DRAIN.
  - In WAIT with response handshake the same cycle: response discarded, -> REQ.
  - In DRAIN: target updated, stay DRAIN.
  - In BOOT: pc updated, -> REQ.
- DRAIN: imem_resp_ready=1. The response is accepted and discarded (slot untouched) -> REQ.
- Arithmetic: pc+4 is modulo 2^32; 32'hFFFF_FFFC wraps to 32'h0000_0000.
- Reset mid-operation: immediately returns all state to reset values, regardless of any outstanding request. Memory-side cleanup is the memory's responsibility.

## Timing

- First request: imem_req_valid=1 in the second cycle after reset_n rises (BOOT occupies one cycle).
- Response accepted in cycle N -> inst_valid=1 with data and PC in cycle N+1.
- Peak throughput is one instruction per 2 cycles (REQ, WAIT) with a memory that responds in the cycle after the request handshake.
- Redirect in cycle N -> inst_valid=0 in N+1. The first request to the target issues in N+1 if no request is outstanding; otherwise it issues in the cycle after the drained response.
- All outputs are registered or decoded from registered state only. There is no combinational path from inputs to outputs except imem_resp_ready, which depends on stall.

## Structure

- Shared package cpu_pkg:
  - fetch_state_t enum (BOOT, REQ, WAIT, DRAIN).
  - INSTR_BYTES = 4.
  - XLEN = 32.
- Sub-module fetch_out_slot: one-entry instruction/PC buffer with load, consume (stall) and flush inputs. It reports "free this cycle" to drive imem_resp_ready.

## Test plan

- Reset then free-running memory (ready=1, response 1 cycle later, data = addr^32'hA5A5_A5A5), stall=0 -> inst_pc sequence 0,4,8,12…, one instruction every 2 cycles, data matches.
- Stall held for 5 cycles with slot full -> imem_resp_ready=0 while stalled, no data lost, inst_pc continues contiguously once stall falls.
- Redirect to 32'h0000_1002 while in WAIT -> one response discarded, next inst_pc = 32'h0000_1000, inst_valid low for the cycle after the redirect.
- Redirect during REQ with imem_req_ready=0 -> imem_req_addr switches to target next cycle with no handshake lost and no extra response accepted.
- RESET_VECTOR=32'hFFFF_FFF8 -> fetch addresses FFFF_FFF8, FFFF_FFFC, 0000_0000.
- reset_n asserted while WAIT with slot full -> all outputs at reset values immediately; refetch from RESET_VECTOR after release.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared CPU front-end definitions: fetch FSM states, word geometry and
// address helpers used by the fetch sequencer and its output slot.
package cpu_pkg;

  localparam int XLEN        = 32;
  localparam int INSTR_BYTES = 4;

  typedef enum logic [1:0] {
    BOOT  = 2'd0,
    REQ   = 2'd1,
    WAIT  = 2'd2,
    DRAIN = 2'd3
  } fetch_state_t;

  // Clears the byte-offset bits so any address becomes an instruction boundary.
  function automatic logic [XLEN-1:0] word_align(input logic [XLEN-1:0] addr);
    return addr & ~(XLEN'(INSTR_BYTES) - XLEN'(1));
  endfunction

  // Sequential fetch address; wraps naturally at the top of the address space.
  function automatic logic [XLEN-1:0] next_word(input logic [XLEN-1:0] addr);
    return addr + XLEN'(INSTR_BYTES);
  endfunction

endpackage

// File: rtl/fetch_out_slot.sv
// One-entry instruction/PC buffer between fetch and decode, with load,
// consume (via stall) and flush, and a same-cycle "free" indication.
module fetch_out_slot
  import cpu_pkg::*;
(
  input  logic            clk,
  input  logic            reset_n,
  input  logic            load,
  input  logic [XLEN-1:0] load_data,
  input  logic [XLEN-1:0] load_pc,
  input  logic            stall,
  input  logic            flush,
  output logic            free,
  output logic            valid,
  output logic [XLEN-1:0] data,
  output logic [XLEN-1:0] pc
);

  // Free when empty or when decode takes the current entry this very cycle.
  assign free = !valid || !stall;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      valid <= 1'b0;
      data  <= '0;
      pc    <= '0;
    end else if (flush) begin
      valid <= 1'b0;
    end else if (load) begin
      valid <= 1'b1;
      data  <= load_data;
      pc    <= load_pc;
    end else if (!stall) begin
      valid <= 1'b0;
    end
  end

endmodule

// File: rtl/fetch_sequencer.sv
// Instruction-fetch controller: owns the PC, keeps at most one memory request
// in flight, buffers returned words for decode and squashes stale responses.
module fetch_sequencer
  import cpu_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_VECTOR = 32'h0000_0000
) (
  input  logic            clk,
  input  logic            reset_n,
  output logic            imem_req_valid,
  input  logic            imem_req_ready,
  output logic [XLEN-1:0] imem_req_addr,
  input  logic            imem_resp_valid,
  output logic            imem_resp_ready,
  input  logic [XLEN-1:0] imem_resp_data,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  input  logic            stall,
  output logic            inst_valid,
  output logic [XLEN-1:0] inst_data,
  output logic [XLEN-1:0] inst_pc
);

  fetch_state_t    state;
  logic [XLEN-1:0] pc;
  logic [XLEN-1:0] fetch_pc;
  logic            req_valid_q;
  logic [XLEN-1:0] target;
  logic            req_hs;
  logic            resp_hs;
  logic            slot_free;
  logic            slot_load;

  assign target          = word_align(redirect_pc);
  assign imem_req_valid  = req_valid_q;
  assign imem_req_addr   = pc;
  assign req_hs          = req_valid_q && imem_req_ready;
  // The only input-to-output path: a full slot can still accept if decode drains it now.
  assign imem_resp_ready = (state == DRAIN) || ((state == WAIT) && slot_free);
  assign resp_hs         = imem_resp_valid && imem_resp_ready;
  assign slot_load       = (state == WAIT) && resp_hs && !redirect_valid;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state       <= BOOT;
      pc          <= word_align(RESET_VECTOR);
      fetch_pc    <= '0;
      req_valid_q <= 1'b0;
    end else begin
      unique case (state)
        BOOT: begin
          if (redirect_valid) pc <= target;
          state       <= REQ;
          req_valid_q <= 1'b1;
        end
        REQ: begin
          // A redirect may retarget a request that has not yet been accepted.
          if (redirect_valid) begin
            pc <= target;
            if (req_hs) begin
              state       <= DRAIN;
              req_valid_q <= 1'b0;
            end
          end else if (req_hs) begin
            fetch_pc    <= pc;
            pc          <= next_word(pc);
            state       <= WAIT;
            req_valid_q <= 1'b0;
          end
        end
        WAIT: begin
          if (redirect_valid) pc <= target;
          if (resp_hs) begin
            state       <= REQ;
            req_valid_q <= 1'b1;
          end else if (redirect_valid) begin
            state <= DRAIN;
          end
        end
        DRAIN: begin
          // Leaving on the response even when redirected again avoids waiting forever.
          if (redirect_valid) pc <= target;
          if (imem_resp_valid) begin
            state       <= REQ;
            req_valid_q <= 1'b1;
          end
        end
        default: begin
          state       <= BOOT;
          req_valid_q <= 1'b0;
        end
      endcase
    end
  end

  fetch_out_slot u_slot (
    .clk       (clk),
    .reset_n   (reset_n),
    .load      (slot_load),
    .load_data (imem_resp_data),
    .load_pc   (fetch_pc),
    .stall     (stall),
    .flush     (redirect_valid),
    .free      (slot_free),
    .valid     (inst_valid),
    .data      (inst_data),
    .pc        (inst_pc)
  );

endmodule

// File: tb/tb_fetch_sequencer.sv
// Bench for fetch_sequencer: a latency-configurable memory model and an
// instruction-stream reference (contiguous PCs, restarted by redirects).
module tb_fetch_sequencer;

  localparam logic [31:0] KEY         = 32'hA5A5_A5A5;
  localparam logic [31:0] WRAP_VECTOR = 32'hFFFF_FFF8;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        imem_req_valid, imem_req_ready, imem_resp_valid, imem_resp_ready;
  logic [31:0] imem_req_addr, imem_resp_data, redirect_pc, inst_data, inst_pc;
  logic        redirect_valid, stall, inst_valid;

  logic        w_req_valid, w_req_ready, w_resp_valid, w_resp_ready;
  logic [31:0] w_req_addr, w_resp_data, w_redirect_pc, w_inst_data, w_inst_pc;
  logic        w_redirect_valid, w_stall, w_inst_valid;

  always #5 clk = ~clk;

  fetch_sequencer #(.RESET_VECTOR(32'h0000_0000)) dut (
    .clk(clk), .reset_n(reset_n),
    .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready), .imem_req_addr(imem_req_addr),
    .imem_resp_valid(imem_resp_valid), .imem_resp_ready(imem_resp_ready), .imem_resp_data(imem_resp_data),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc), .stall(stall),
    .inst_valid(inst_valid), .inst_data(inst_data), .inst_pc(inst_pc)
  );

  fetch_sequencer #(.RESET_VECTOR(WRAP_VECTOR)) dut_wrap (
    .clk(clk), .reset_n(reset_n),
    .imem_req_valid(w_req_valid), .imem_req_ready(w_req_ready), .imem_req_addr(w_req_addr),
    .imem_resp_valid(w_resp_valid), .imem_resp_ready(w_resp_ready), .imem_resp_data(w_resp_data),
    .redirect_valid(w_redirect_valid), .redirect_pc(w_redirect_pc), .stall(w_stall),
    .inst_valid(w_inst_valid), .inst_data(w_inst_data), .inst_pc(w_inst_pc)
  );

  int          n_tests = 0;
  int          n_fail  = 0;
  int          cyc     = 0;
  logic [31:0] mem_q[$];
  int          mem_lat, lat_min, lat_max, ready_mode;
  logic [31:0] exp_pc;

  logic        obs_req_valid, obs_req_hs, obs_resp_ready, obs_resp_hs, obs_inst_valid, obs_consume;
  logic [31:0] obs_req_addr, obs_pc, obs_data, obs_exp;
  int          obs_outstanding;

  // One clock of memory behaviour plus reference-stream bookkeeping; starts and ends at a negedge.
  task automatic cycle_step();
    imem_resp_valid = (mem_q.size() != 0) && (mem_lat == 0);
    if (imem_resp_valid) imem_resp_data = mem_q[0] ^ KEY;
    else                 imem_resp_data = $urandom;
    case (ready_mode)
      0:       imem_req_ready = 1'b1;
      1:       imem_req_ready = 1'($urandom_range(0, 1));
      default: imem_req_ready = 1'b0;
    endcase
    #1;
    obs_req_valid   = imem_req_valid;
    obs_req_addr    = imem_req_addr;
    obs_req_hs      = imem_req_valid && imem_req_ready;
    obs_resp_ready  = imem_resp_ready;
    obs_resp_hs     = imem_resp_valid && imem_resp_ready;
    obs_inst_valid  = inst_valid;
    obs_pc          = inst_pc;
    obs_data        = inst_data;
    obs_consume     = inst_valid && !stall && !redirect_valid;
    obs_outstanding = mem_q.size();
    obs_exp         = exp_pc;
    if (redirect_valid)   exp_pc = redirect_pc & ~32'h3;
    else if (obs_consume) exp_pc = exp_pc + 32'd4;
    if (obs_resp_hs) void'(mem_q.pop_front());
    else if (mem_q.size() != 0 && mem_lat != 0) mem_lat--;
    if (obs_req_hs) begin
      mem_q.push_back(imem_req_addr);
      mem_lat = $urandom_range(lat_max, lat_min);
    end
    cyc++;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    stall = 1'b0; redirect_valid = 1'b0; redirect_pc = '0;
    imem_req_ready = 1'b0; imem_resp_valid = 1'b0; imem_resp_data = '0;
    w_req_ready = 1'b0; w_resp_valid = 1'b0; w_resp_data = '0;
    w_redirect_valid = 1'b0; w_redirect_pc = '0; w_stall = 1'b0;
    mem_q.delete(); mem_lat = 0; lat_min = 0; lat_max = 0; ready_mode = 0;
    exp_pc = 32'h0000_0000;
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
  endtask

  task automatic test_reset();
    do_reset();
    reset_n = 1'b0;
    #1;
    n_tests++; if (imem_req_valid !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_req_valid: got %b expected 0", imem_req_valid); end
    n_tests++; if (imem_resp_ready !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_resp_ready: got %b expected 0", imem_resp_ready); end
    n_tests++; if (inst_valid !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_inst_valid: got %b expected 0", inst_valid); end
    n_tests++; if (inst_data !== 32'h0) begin n_fail++; $display("[TB] FAIL reset_inst_data: got %h expected 0", inst_data); end
    n_tests++; if (inst_pc !== 32'h0) begin n_fail++; $display("[TB] FAIL reset_inst_pc: got %h expected 0", inst_pc); end
    @(negedge clk);
    reset_n = 1'b1;
    cycle_step();
    n_tests++; if (obs_req_valid !== 1'b0) begin n_fail++; $display("[TB] FAIL boot_req_valid: got %b expected 0", obs_req_valid); end
    cycle_step();
    n_tests++; if (obs_req_valid !== 1'b1) begin n_fail++; $display("[TB] FAIL first_req_valid: got %b expected 1", obs_req_valid); end
    n_tests++; if (obs_req_addr !== 32'h0) begin n_fail++; $display("[TB] FAIL first_req_addr: got %h expected 00000000", obs_req_addr); end
  endtask

  task automatic test_free_run();
    int consumed = 0;
    int last = -1;
    do_reset();
    for (int i = 0; i < 40; i++) begin
      cycle_step();
      if (obs_consume) begin
        n_tests++; if (obs_pc !== obs_exp) begin n_fail++; $display("[TB] FAIL free_pc: got %h expected %h", obs_pc, obs_exp); end
        n_tests++; if (obs_data !== (obs_exp ^ KEY)) begin n_fail++; $display("[TB] FAIL free_data: got %h expected %h", obs_data, obs_exp ^ KEY); end
        if (last >= 0) begin
          n_tests++; if (cyc - last != 2) begin n_fail++; $display("[TB] FAIL free_rate: got spacing %0d expected 2", cyc - last); end
        end
        last = cyc;
        consumed++;
      end
    end
    n_tests++; if (consumed != 19) begin n_fail++; $display("[TB] FAIL free_count: got %0d expected 19", consumed); end
  endtask

  task automatic test_stall();
    int consumed = 0;
    do_reset();
    stall = 1'b1;
    for (int i = 0; i < 20; i++) begin
      cycle_step();
      if (obs_inst_valid) break;
    end
    n_tests++; if (!obs_inst_valid) begin n_fail++; $display("[TB] FAIL stall_fill: got inst_valid 0 expected 1 within 20 cycles"); end
    for (int i = 0; i < 5; i++) begin
      cycle_step();
      n_tests++; if (obs_resp_ready !== 1'b0) begin n_fail++; $display("[TB] FAIL stall_resp_ready: got %b expected 0", obs_resp_ready); end
      n_tests++; if (obs_inst_valid !== 1'b1 || obs_pc !== 32'h0) begin n_fail++; $display("[TB] FAIL stall_hold: got valid %b pc %h expected 1 00000000", obs_inst_valid, obs_pc); end
    end
    stall = 1'b0;
    for (int i = 0; i < 12; i++) begin
      cycle_step();
      if (obs_consume) begin
        n_tests++; if (obs_pc !== obs_exp || obs_data !== (obs_exp ^ KEY)) begin n_fail++; $display("[TB] FAIL stall_resume: got %h/%h expected %h/%h", obs_pc, obs_data, obs_exp, obs_exp ^ KEY); end
        consumed++;
      end
    end
    n_tests++; if (consumed < 5) begin n_fail++; $display("[TB] FAIL stall_progress: got %0d expected at least 5", consumed); end
  endtask

  task automatic test_redirect_wait();
    int  resp_cnt = 0;
    bit  first_req = 1'b1;
    bit  done = 1'b0;
    do_reset();
    lat_min = 2; lat_max = 2;
    stall = 1'b1;
    for (int i = 0; i < 20; i++) begin
      cycle_step();
      if (obs_req_hs && obs_inst_valid) break;
    end
    n_tests++; if (!(obs_req_hs && obs_inst_valid)) begin n_fail++; $display("[TB] FAIL rw_setup: got no request with full slot expected one within 20 cycles"); end
    redirect_valid = 1'b1; redirect_pc = 32'h0000_1002;
    cycle_step();
    redirect_valid = 1'b0; stall = 1'b0;
    for (int i = 0; i < 30 && !done; i++) begin
      cycle_step();
      if (i == 0) begin
        n_tests++; if (obs_inst_valid !== 1'b0) begin n_fail++; $display("[TB] FAIL rw_flush: got inst_valid %b expected 0", obs_inst_valid); end
      end
      if (obs_resp_hs) resp_cnt++;
      if (obs_req_hs && first_req) begin
        first_req = 1'b0;
        n_tests++; if (obs_req_addr !== 32'h0000_1000) begin n_fail++; $display("[TB] FAIL rw_req_addr: got %h expected 00001000", obs_req_addr); end
      end
      if (obs_consume) begin
        done = 1'b1;
        n_tests++; if (obs_pc !== 32'h0000_1000 || obs_data !== (32'h0000_1000 ^ KEY)) begin n_fail++; $display("[TB] FAIL rw_target: got %h/%h expected 00001000/%h", obs_pc, obs_data, 32'h0000_1000 ^ KEY); end
        n_tests++; if (resp_cnt != 2) begin n_fail++; $display("[TB] FAIL rw_discard: got %0d responses expected 2", resp_cnt); end
      end
    end
    n_tests++; if (!done) begin n_fail++; $display("[TB] FAIL rw_timeout: got no instruction expected one within 30 cycles"); end
  endtask

  task automatic test_redirect_req();
    int resp_cnt = 0;
    bit first_req = 1'b1;
    bit done = 1'b0;
    do_reset();
    ready_mode = 2;
    for (int i = 0; i < 10; i++) begin
      cycle_step();
      if (obs_req_valid) break;
    end
    cycle_step();
    n_tests++; if (obs_req_valid !== 1'b1 || obs_req_addr !== 32'h0) begin n_fail++; $display("[TB] FAIL rq_hold: got %b/%h expected 1/00000000", obs_req_valid, obs_req_addr); end
    redirect_valid = 1'b1; redirect_pc = 32'h0000_2467;
    cycle_step();
    redirect_valid = 1'b0;
    cycle_step();
    n_tests++; if (obs_req_valid !== 1'b1 || obs_req_addr !== 32'h0000_2464) begin n_fail++; $display("[TB] FAIL rq_retarget: got %b/%h expected 1/00002464", obs_req_valid, obs_req_addr); end
    n_tests++; if (obs_inst_valid !== 1'b0) begin n_fail++; $display("[TB] FAIL rq_flush: got inst_valid %b expected 0", obs_inst_valid); end
    ready_mode = 0;
    for (int i = 0; i < 20 && !done; i++) begin
      cycle_step();
      if (obs_resp_hs) resp_cnt++;
      if (obs_req_hs && first_req) begin
        first_req = 1'b0;
        n_tests++; if (obs_req_addr !== 32'h0000_2464) begin n_fail++; $display("[TB] FAIL rq_first_hs: got %h expected 00002464", obs_req_addr); end
      end
      if (obs_consume) begin
        done = 1'b1;
        n_tests++; if (obs_pc !== 32'h0000_2464) begin n_fail++; $display("[TB] FAIL rq_target: got %h expected 00002464", obs_pc); end
        n_tests++; if (resp_cnt != 1) begin n_fail++; $display("[TB] FAIL rq_extra_resp: got %0d responses expected 1", resp_cnt); end
      end
    end
    n_tests++; if (!done) begin n_fail++; $display("[TB] FAIL rq_timeout: got no instruction expected one within 20 cycles"); end
  endtask

  task automatic test_random();
    int          consumed = 0;
    bit          prev_pending = 1'b0;
    bit          prev_redirect = 1'b0;
    logic [31:0] prev_addr = '0;
    do_reset();
    ready_mode = 1; lat_min = 0; lat_max = 2;
    for (int i = 0; i < 1500; i++) begin
      stall          = ($urandom_range(0, 9) < 3);
      redirect_valid = !redirect_valid && ($urandom_range(0, 19) == 0);
      redirect_pc    = $urandom;
      cycle_step();
      if (obs_consume) begin
        consumed++;
        n_tests++; if (obs_pc !== obs_exp || obs_data !== (obs_exp ^ KEY)) begin n_fail++; $display("[TB] FAIL rnd_stream: got %h/%h expected %h/%h", obs_pc, obs_data, obs_exp, obs_exp ^ KEY); end
      end
      if (obs_req_hs) begin
        n_tests++; if (obs_outstanding != 0) begin n_fail++; $display("[TB] FAIL rnd_outstanding: got %0d in flight expected 0", obs_outstanding); end
      end
      if (prev_pending && !prev_redirect) begin
        n_tests++; if (obs_req_valid !== 1'b1 || obs_req_addr !== prev_addr) begin n_fail++; $display("[TB] FAIL rnd_req_hold: got %b/%h expected 1/%h", obs_req_valid, obs_req_addr, prev_addr); end
      end
      if (prev_redirect) begin
        n_tests++; if (obs_inst_valid !== 1'b0) begin n_fail++; $display("[TB] FAIL rnd_flush: got inst_valid %b expected 0", obs_inst_valid); end
      end
      prev_pending  = obs_req_valid && !obs_req_hs;
      prev_addr     = obs_req_addr;
      prev_redirect = redirect_valid;
    end
    redirect_valid = 1'b0;
    n_tests++; if (consumed < 100) begin n_fail++; $display("[TB] FAIL rnd_progress: got %0d instructions expected at least 100", consumed); end
  endtask

  task automatic test_reset_mid();
    bit done = 1'b0;
    do_reset();
    lat_min = 2; lat_max = 2;
    stall = 1'b1;
    for (int i = 0; i < 20; i++) begin
      cycle_step();
      if (obs_req_hs && obs_inst_valid) break;
    end
    n_tests++; if (!(obs_req_hs && obs_inst_valid)) begin n_fail++; $display("[TB] FAIL rm_setup: got no request with full slot expected one within 20 cycles"); end
    reset_n = 1'b0;
    #1;
    n_tests++; if (imem_req_valid !== 1'b0 || imem_resp_ready !== 1'b0) begin n_fail++; $display("[TB] FAIL rm_req_resp: got %b/%b expected 0/0", imem_req_valid, imem_resp_ready); end
    n_tests++; if (inst_valid !== 1'b0 || inst_data !== 32'h0 || inst_pc !== 32'h0) begin n_fail++; $display("[TB] FAIL rm_slot: got %b/%h/%h expected 0/0/0", inst_valid, inst_data, inst_pc); end
    mem_q.delete(); mem_lat = 0; lat_min = 0; lat_max = 0;
    imem_resp_valid = 1'b0; stall = 1'b0; exp_pc = 32'h0;
    @(negedge clk);
    reset_n = 1'b1;
    cycle_step();
    cycle_step();
    n_tests++; if (obs_req_valid !== 1'b1 || obs_req_addr !== 32'h0) begin n_fail++; $display("[TB] FAIL rm_refetch: got %b/%h expected 1/00000000", obs_req_valid, obs_req_addr); end
    for (int i = 0; i < 10 && !done; i++) begin
      cycle_step();
      if (obs_consume) begin
        done = 1'b1;
        n_tests++; if (obs_pc !== 32'h0 || obs_data !== KEY) begin n_fail++; $display("[TB] FAIL rm_first_inst: got %h/%h expected 00000000/%h", obs_pc, obs_data, KEY); end
      end
    end
    n_tests++; if (!done) begin n_fail++; $display("[TB] FAIL rm_timeout: got no instruction expected one within 10 cycles"); end
  endtask

  task automatic test_wrap();
    int          nreq = 0;
    int          ncons = 0;
    bit          pend = 1'b0;
    logic [31:0] pend_addr = '0;
    logic [31:0] e;
    do_reset();
    for (int i = 0; i < 20; i++) begin
      w_req_ready  = 1'b1;
      w_resp_valid = pend;
      w_resp_data  = pend_addr ^ KEY;
      #1;
      if (w_inst_valid && ncons < 3) begin
        e = WRAP_VECTOR + 32'(4 * ncons);
        n_tests++; if (w_inst_pc !== e || w_inst_data !== (e ^ KEY)) begin n_fail++; $display("[TB] FAIL wrap_inst: got %h/%h expected %h/%h", w_inst_pc, w_inst_data, e, e ^ KEY); end
        ncons++;
      end
      if (w_resp_valid && w_resp_ready) pend = 1'b0;
      if (w_req_valid && w_req_ready) begin
        e = WRAP_VECTOR + 32'(4 * nreq);
        if (nreq < 3) begin
          n_tests++; if (w_req_addr !== e) begin n_fail++; $display("[TB] FAIL wrap_addr: got %h expected %h", w_req_addr, e); end
        end
        nreq++;
        pend = 1'b1;
        pend_addr = w_req_addr;
      end
      @(posedge clk);
      @(negedge clk);
    end
    w_req_ready = 1'b0; w_resp_valid = 1'b0;
    n_tests++; if (nreq < 3 || ncons < 3) begin n_fail++; $display("[TB] FAIL wrap_progress: got %0d requests %0d instructions expected at least 3 each", nreq, ncons); end
  endtask

  initial begin
    test_reset();
    test_free_run();
    test_stall();
    test_redirect_wait();
    test_redirect_req();
    test_random();
    test_reset_mid();
    test_wrap();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: got no completion expected finish before time limit");
    $fatal(1, "[TB] simulation time limit reached");
  end

endmodule
